// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit for the MEM pipeline stage.
// Accepts one instruction per IDLE cycle from EX, passes non-memory ops through
// in one cycle, and runs loads/stores over a valid/ready request plus response
// bus using an IDLE/REQ/WAIT FSM. Sub-word stores are lane-replicated with byte
// enables; loads are lane-selected and sign/zero extended.
// A WAIT watchdog (TIMEOUT cycles, 0 = off) retires a hung access as a fault.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses
// (fault cause 01, no bus request); otherwise they are aligned down.
module mem_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              EX_valid,
  input  logic              EX_Mem_rd_en,
  input  logic              EX_Mem_wr_en,
  input  logic [2:0]        EX_Mem_op,
  input  logic              EX_MemToReg,
  input  logic              EX_RegFile_wr_en,
  input  logic [4:0]        EX_Rd_addr,
  input  logic [31:0]       EX_ALU_result,
  input  logic [31:0]       EX_Rs2_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wr_data,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              MEM_stall,
  output logic              MEM_valid,
  output logic              MEM_MemToReg,
  output logic              MEM_RegFile_wr_en,
  output logic [4:0]        MEM_Rd_addr,
  output logic [31:0]       MEM_dout,
  output logic [31:0]       MEM_ALU_result,
  output logic              MEM_fault,
  output logic [1:0]        MEM_fault_cause
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_t;

  // Counter runs 0..TIMEOUT-1 across the WAIT cycles of one access.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_BUS   = 2'b10;
  localparam logic [1:0] CAUSE_TMO   = 2'b11;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic [1:0] CAUSE_ALIGN = 2'b01;
`endif

  // Lane offset actually used: bytes keep a[1:0], halfwords snap to a[1], words to lane 0.
  function automatic logic [1:0] lane_off(input logic [2:0] op, input logic [1:0] a);
    case (op[1:0])
      2'b00:   lane_off = a;
      2'b01:   lane_off = {a[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

  // Byte enables for the access size at the chosen lane.
  function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] off);
    case (op[1:0])
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Store data is replicated across lanes so memory only needs the byte enables.
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] d);
    case (op[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Lane select plus sign/zero extension of the load response word.
  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[1], 4'b0000} +: 16];
    case (op)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'h00_0000, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'h0000, h};
      default: load_ext = d;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfword on an odd address or word off a 4-byte boundary.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction
`endif

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       op_r;
  logic [1:0]       off_r;
  logic             is_store_r;
  logic             m2r_r;
  logic             rf_we_r;
  logic [4:0]       rd_r;
  logic [31:0]      alu_r;

  logic             ex_mem_s;
  logic [1:0]       ex_off_s;
  logic [3:0]       ex_be_s;
  logic [31:0]      ex_wdata_s;
  logic [31:0]      rsp_dout_s;
  logic             rsp_rf_we_s;
`ifdef LSU_MISALIGN_TRAP_EN
  logic             ex_misalign_s;
`endif

  assign MEM_stall = (state_r != ST_IDLE);

  // Request formatting from EX and response formatting for the captured op.
  always_comb begin
    ex_mem_s = EX_Mem_rd_en | EX_Mem_wr_en;
    ex_off_s = lane_off(EX_Mem_op, EX_ALU_result[1:0]);
    ex_be_s  = byte_en(EX_Mem_op, ex_off_s);
    if (EX_Mem_wr_en) begin
      ex_wdata_s = store_data(EX_Mem_op, EX_Rs2_data);
    end else begin
      ex_wdata_s = 32'h0000_0000;
    end
    if (is_store_r || mem_rsp_err) begin
      rsp_dout_s = 32'h0000_0000;
    end else begin
      rsp_dout_s = load_ext(op_r, off_r, mem_rsp_data);
    end
    rsp_rf_we_s = rf_we_r & ~is_store_r & ~mem_rsp_err;
`ifdef LSU_MISALIGN_TRAP_EN
    ex_misalign_s = misaligned(EX_Mem_op, EX_ALU_result[1:0]);
`endif
  end

  // Main FSM: accept, issue request, await response or timeout, retire to MEM.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r           <= ST_IDLE;
      cnt_r             <= '0;
      op_r              <= 3'b000;
      off_r             <= 2'b00;
      is_store_r        <= 1'b0;
      m2r_r             <= 1'b0;
      rf_we_r           <= 1'b0;
      rd_r              <= 5'd0;
      alu_r             <= 32'h0000_0000;
      mem_req_valid     <= 1'b0;
      mem_addr          <= '0;
      mem_wr_en         <= 1'b0;
      mem_be            <= 4'b0000;
      mem_wr_data       <= 32'h0000_0000;
      MEM_valid         <= 1'b0;
      MEM_MemToReg      <= 1'b0;
      MEM_RegFile_wr_en <= 1'b0;
      MEM_Rd_addr       <= 5'd0;
      MEM_dout          <= 32'h0000_0000;
      MEM_ALU_result    <= 32'h0000_0000;
      MEM_fault         <= 1'b0;
      MEM_fault_cause   <= CAUSE_NONE;
    end else begin
      MEM_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (EX_valid && ex_mem_s) begin
            op_r       <= EX_Mem_op;
            off_r      <= ex_off_s;
            is_store_r <= EX_Mem_wr_en;
            m2r_r      <= EX_MemToReg;
            rf_we_r    <= EX_RegFile_wr_en;
            rd_r       <= EX_Rd_addr;
            alu_r      <= EX_ALU_result;
`ifdef LSU_MISALIGN_TRAP_EN
            if (ex_misalign_s) begin
              state_r           <= ST_IDLE;
              MEM_valid         <= 1'b1;
              MEM_MemToReg      <= EX_MemToReg;
              MEM_RegFile_wr_en <= 1'b0;
              MEM_Rd_addr       <= EX_Rd_addr;
              MEM_dout          <= 32'h0000_0000;
              MEM_ALU_result    <= EX_ALU_result;
              MEM_fault         <= 1'b1;
              MEM_fault_cause   <= CAUSE_ALIGN;
            end else begin
              state_r       <= ST_REQ;
              mem_req_valid <= 1'b1;
              mem_addr      <= {EX_ALU_result[ADDR_W-1:2], 2'b00};
              mem_wr_en     <= EX_Mem_wr_en;
              mem_be        <= ex_be_s;
              mem_wr_data   <= ex_wdata_s;
            end
`else
            state_r       <= ST_REQ;
            mem_req_valid <= 1'b1;
            mem_addr      <= {EX_ALU_result[ADDR_W-1:2], 2'b00};
            mem_wr_en     <= EX_Mem_wr_en;
            mem_be        <= ex_be_s;
            mem_wr_data   <= ex_wdata_s;
`endif
          end else if (EX_valid) begin
            state_r           <= ST_IDLE;
            MEM_valid         <= 1'b1;
            MEM_MemToReg      <= EX_MemToReg;
            MEM_RegFile_wr_en <= EX_RegFile_wr_en;
            MEM_Rd_addr       <= EX_Rd_addr;
            MEM_dout          <= 32'h0000_0000;
            MEM_ALU_result    <= EX_ALU_result;
            MEM_fault         <= 1'b0;
            MEM_fault_cause   <= CAUSE_NONE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state_r       <= ST_WAIT;
            mem_req_valid <= 1'b0;
            cnt_r         <= '0;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            state_r           <= ST_IDLE;
            MEM_valid         <= 1'b1;
            MEM_MemToReg      <= m2r_r;
            MEM_RegFile_wr_en <= rsp_rf_we_s;
            MEM_Rd_addr       <= rd_r;
            MEM_dout          <= rsp_dout_s;
            MEM_ALU_result    <= alu_r;
            MEM_fault         <= mem_rsp_err;
            MEM_fault_cause   <= mem_rsp_err ? CAUSE_BUS : CAUSE_NONE;
          end else if ((TIMEOUT != 0) && (cnt_r == CNT_MAX)) begin
            state_r           <= ST_IDLE;
            MEM_valid         <= 1'b1;
            MEM_MemToReg      <= m2r_r;
            MEM_RegFile_wr_en <= 1'b0;
            MEM_Rd_addr       <= rd_r;
            MEM_dout          <= 32'h0000_0000;
            MEM_ALU_result    <= alu_r;
            MEM_fault         <= 1'b1;
            MEM_fault_cause   <= CAUSE_TMO;
          end else begin
            state_r <= ST_WAIT;
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, data-memory byte-address width, legal 12..32.
REQ-002 Parameter TIMEOUT, default 256, max WAIT cycles before timeout fault; 0 disables timeout.
REQ-003 Clk  in  1  sole clock, all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 EX_valid  in  1  EX stage presents a valid instruction.
REQ-006 EX_Mem_rd_en, EX_Mem_wr_en  in  1 each  load / store request (never both set).
REQ-007 EX_Mem_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 EX_MemToReg, EX_RegFile_wr_en  in  1 each; EX_Rd_addr  in  5; EX_ALU_result, EX_Rs2_data  in  32.
REQ-009 mem_req_valid  out  1; mem_req_ready  in  1  request handshake.
REQ-010 mem_addr  out  ADDR_W  word-aligned (bits[1:0]=00); mem_wr_en  out  1; mem_be  out  4; mem_wr_data  out  32.
REQ-011 mem_rsp_valid  in  1; mem_rsp_data  in  32; mem_rsp_err  in  1  response (reads and write acks).
REQ-012 MEM_stall  out  1  EX must hold its outputs while high.
REQ-013 MEM_valid, MEM_MemToReg, MEM_RegFile_wr_en  out  1 each; MEM_Rd_addr  out  5; MEM_dout, MEM_ALU_result  out  32.
REQ-014 MEM_fault  out  1; MEM_fault_cause  out  2  (00 none, 01 misaligned, 10 bus error, 11 timeout).

Function
REQ-015 FSM states IDLE, REQ, WAIT; MEM_stall = (state != IDLE).
REQ-016 Accept = IDLE & EX_valid; non-memory op accepted -> MEM_* registered, MEM_valid=1 next cycle, state stays IDLE.
REQ-017 Memory op accepted -> address/op/data/Rd captured, IDLE->REQ.
REQ-018 REQ: mem_req_valid=1 with stable addr/be/data until mem_req_ready; on ready -> WAIT, timeout counter cleared.
REQ-019 WAIT: mem_rsp_valid -> IDLE, MEM_valid=1 for exactly one cycle next cycle; mem_rsp_valid ignored in IDLE and REQ.
REQ-020 Minimum memory-op latency: accept at N, req at N+1, rsp at N+2, MEM_valid at N+3.
REQ-021 Store: mem_wr_data = SB byte replicated x4, SH halfword replicated x2, SW as-is; mem_be = SB 0001<<a[1:0], SH 0011<<{a[1],0}, SW 1111.
REQ-022 Load: select byte lane a[1:0] / halfword a[1] from mem_rsp_data; B/H sign-extend from selected MSB, BU/HU zero-extend, W as-is.
REQ-023 mem_rsp_err=1 -> MEM_fault=1, cause 10.
REQ-024 TIMEOUT>0: counter reaches TIMEOUT in WAIT without response -> IDLE, MEM_valid=1, fault cause 11; response in same cycle wins, no fault.
REQ-025 Any fault forces MEM_RegFile_wr_en=0 for that instruction; MEM_ALU_result still carries address.
REQ-026 Store completion: MEM_valid=1, MEM_RegFile_wr_en=0, MEM_dout=0.
REQ-027 MEM_valid=0 in every cycle without a completion; other MEM_* then hold their last value.

Reset
REQ-028 Reset -> state IDLE, counter 0, all outputs 0 (mem_req_valid, mem_wr_en, mem_be, MEM_valid, MEM_fault, MEM_stall included) next cycle.
REQ-029 Reset mid-REQ/WAIT abandons the operation; a later stale response is ignored (IDLE rule).

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN defined: H with a[0]=1 or W with a[1:0]!=0 issues no memory request; MEM_valid next cycle with MEM_fault=1, cause 01.
REQ-031 Macro undefined: misaligned offsets aligned down (H uses a[1] lane, W lane 0), access proceeds normally, cause 01 never raised.

Verification
REQ-032 LB at 0x103, rsp 0x80FF_0000, ready immediate -> MEM_dout 0xFFFF_FF80 at N+3, MEM_stall high N+1..N+2.
REQ-033 SH 0x0000_1234 at 0x202 -> mem_be 1100, mem_wr_data 0x1234_1234, mem_addr 0x200, MEM_RegFile_wr_en 0 on completion.
REQ-034 LHU at 0x4, mem_req_ready low 5 cycles, rsp 0x0000_8001 -> mem_req_valid held 6 cycles, MEM_dout 0x0000_8001.
REQ-035 TIMEOUT=4, LW, no response -> MEM_fault=1, cause 11 after 4 WAIT cycles; response on 4th cycle -> no fault.
REQ-036 LW at 0x6: with LSU_MISALIGN_TRAP_EN cause 01, mem_req_valid never high; without, mem_addr 0x4, normal load.
REQ-037 Reset asserted in WAIT then rsp pulse -> MEM_valid stays 0, next ADD passes through with MEM_valid one cycle later.
